frontend_pipe_ctrl: RTL and testbench

//  Central stall/clear sequencer for the frontend pipeline registers (IF->ID, ID->RR, RR->DP).

---
 rtl/frontend_pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_frontend_pipe_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/frontend_pipe_ctrl.sv
// Frontend pipeline stall/clear sequencer: NORMAL -> FLUSH -> RECOVER -> NORMAL.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module frontend_pipe_ctrl #(
    parameter int unsigned IQ_NUM         = 3,
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rob_full,
    input  logic [IQ_NUM-1:0] iq_full,
    input  logic              freelist_empty,
    input  logic              br_mispredict,
    input  logic              exception,
    output logic              stall_if_id,
    output logic              stall_id_rr,
    output logic              stall_rr_dp,
    output logic              clear_if_id,
    output logic              clear_id_rr,
    output logic              clear_rr_dp,
    output logic              fetch_redirect,
    output logic              rename_recover,
    output logic [1:0]        ctrl_state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_stall_cycles,
    output logic [CNT_WIDTH-1:0] perf_flush_count
`endif
);

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    localparam logic [3:0] RCNT_RELOAD = 4'(RECOVER_CYCLES - 1);

    if (RECOVER_CYCLES < 1 || RECOVER_CYCLES > 15 || CNT_WIDTH < 1) begin : g_bad_params
        $error("frontend_pipe_ctrl: RECOVER_CYCLES must be 1..15 and CNT_WIDTH >= 1");
    end

    state_t     state, state_nxt;
    logic [3:0] rcnt, rcnt_nxt;
    logic       busy;
    logic       evt;
    logic       stall_all;
    logic       clear_all;

    assign busy = rob_full | (|iq_full) | freelist_empty;
    // A simultaneous mispredict and exception is one event and one flush.
    assign evt  = br_mispredict | exception;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_NORMAL;
            rcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
        end
    end

    // NOTE: defaults first so every path assigns every target and no latch is inferred.
    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        case (state)
            ST_NORMAL: begin
                if (evt) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (evt) begin
                    state_nxt = ST_FLUSH;
                end else begin
                    state_nxt = ST_RECOVER;
                    rcnt_nxt  = RCNT_RELOAD;
                end
            end
            ST_RECOVER: begin
                if (evt) begin
                    state_nxt = ST_FLUSH;
                end else if (rcnt == 4'd0) begin
                    state_nxt = ST_NORMAL;
                end else begin
                    rcnt_nxt = rcnt - 4'd1;
                end
            end
            default: state_nxt = ST_NORMAL;
        endcase
    end

    // Reset forces the registers clear so nothing stale reaches the backend.
    always_comb begin
        stall_all      = 1'b0;
        clear_all      = 1'b0;
        fetch_redirect = 1'b0;
        rename_recover = 1'b0;
        if (reset) begin
            clear_all = 1'b1;
        end else begin
            case (state)
                ST_NORMAL:  stall_all = busy;
                ST_FLUSH: begin
                    clear_all      = 1'b1;
                    fetch_redirect = 1'b1;
                end
                ST_RECOVER: begin
                    stall_all      = 1'b1;
                    rename_recover = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign stall_if_id = stall_all;
    assign stall_id_rr = stall_all;
    assign stall_rr_dp = stall_all;
    assign clear_if_id = clear_all;
    assign clear_id_rr = clear_all;
    assign clear_rr_dp = clear_all;
    assign ctrl_state  = state;

`ifdef PIPE_CTRL_PERF_EN
    // Every cycle spent in FLUSH was entered by an event, so count FLUSH-bound transitions.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flush_count  <= '0;
        end else begin
            if (state == ST_NORMAL && busy && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if (state_nxt == ST_FLUSH && perf_flush_count != '1)
                perf_flush_count <= perf_flush_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_frontend_pipe_ctrl.sv
// Scoreboard bench for frontend_pipe_ctrl: stimulus pushes hand-computed expected
// output vectors; a monitor pops and compares once per cycle on the falling edge.
module tb_frontend_pipe_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       rob_full;
    logic [2:0] iq_full;
    logic       freelist_empty;
    logic       br_mispredict;
    logic       exception;
    logic       stall_if_id, stall_id_rr, stall_rr_dp;
    logic       clear_if_id, clear_id_rr, clear_rr_dp;
    logic       fetch_redirect, rename_recover;
    logic [1:0] ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

    frontend_pipe_ctrl #(.IQ_NUM(3), .RECOVER_CYCLES(2), .CNT_WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .rob_full       (rob_full),
        .iq_full        (iq_full),
        .freelist_empty (freelist_empty),
        .br_mispredict  (br_mispredict),
        .exception      (exception),
        .stall_if_id    (stall_if_id),
        .stall_id_rr    (stall_id_rr),
        .stall_rr_dp    (stall_rr_dp),
        .clear_if_id    (clear_if_id),
        .clear_id_rr    (clear_id_rr),
        .clear_rr_dp    (clear_rr_dp),
        .fetch_redirect (fetch_redirect),
        .rename_recover (rename_recover),
        .ctrl_state     (ctrl_state)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
`endif
    );

    always #5 clock = ~clock;

    // {ctrl_state, stall if/id/rr, clear if/id/rr, fetch_redirect, rename_recover}
    localparam logic [9:0] E_IDLE  = {2'd0, 3'b000, 3'b000, 1'b0, 1'b0};
    localparam logic [9:0] E_BUSY  = {2'd0, 3'b111, 3'b000, 1'b0, 1'b0};
    localparam logic [9:0] E_FLUSH = {2'd1, 3'b000, 3'b111, 1'b1, 1'b0};
    localparam logic [9:0] E_RECOV = {2'd2, 3'b111, 3'b000, 1'b0, 1'b1};
    localparam logic [9:0] E_RST0  = {2'd0, 3'b000, 3'b111, 1'b0, 1'b0};
    localparam logic [9:0] E_RST_R = {2'd2, 3'b000, 3'b111, 1'b0, 1'b0};

    typedef struct {
        logic [9:0] exp;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    logic stim_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic rob, input logic [2:0] iq, input logic fl,
                        input logic br, input logic ex, input logic [9:0] exp, input string name);
        exp_t e;
        #1;
        reset          = rst;
        rob_full       = rob;
        iq_full        = iq;
        freelist_empty = fl;
        br_mispredict  = br;
        exception      = ex;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
        @(posedge clock);
    endtask

    // Monitor: outputs are presented every cycle, so one pop per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.name, {22'd0, ctrl_state, stall_if_id, stall_id_rr, stall_rr_dp,
                               clear_if_id, clear_id_rr, clear_rr_dp,
                               fetch_redirect, rename_recover}, {22'd0, e.exp});
            end
        end
    end

    initial begin
        reset = 1'b1; rob_full = 1'b0; iq_full = 3'b000; freelist_empty = 1'b0;
        br_mispredict = 1'b0; exception = 1'b0;
        @(posedge clock);
        //    rst  rob  iq      fl   br   ex
        step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_RST0,  "reset_hold");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IDLE,  "after_reset");
        step(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, E_BUSY,  "rob_full_1");
        step(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, E_BUSY,  "rob_full_2");
        step(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, E_BUSY,  "rob_full_3");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IDLE,  "busy_released");
        step(1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, E_BUSY,  "iq_full_busy");
        step(1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, E_BUSY,  "freelist_busy");
        // mispredict, RECOVER_CYCLES = 2
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, E_IDLE,  "br_evt_cycle");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_FLUSH, "br_flush");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_RECOV, "br_recov_1");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_RECOV, "br_recov_2");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IDLE,  "br_back_normal");
        // exception during first RECOVER cycle restarts the sequence; busy ignored
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, E_IDLE,  "re_br_evt");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_FLUSH, "re_flush_1");
        step(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, E_RECOV, "re_exc_in_recov");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_FLUSH, "re_flush_2");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_RECOV, "re_recov_1");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_RECOV, "re_recov_2");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IDLE,  "re_normal");
        // simultaneous events -> single flush; busy ignored in FLUSH/RECOVER
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, E_IDLE,  "both_evt");
        step(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, E_FLUSH, "both_flush_busy");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_RECOV, "both_recov_1");
        step(1'b0, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, E_RECOV, "both_recov_busy");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IDLE,  "both_normal");
        // event during FLUSH extends FLUSH
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, E_IDLE,  "ff_evt");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, E_FLUSH, "ff_flush_evt");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_FLUSH, "ff_flush_again");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_RECOV, "ff_recov_1");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_RECOV, "ff_recov_2");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IDLE,  "ff_normal");
        // event on the rcnt==0 cycle overrides the exit
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, E_IDLE,  "rz_evt");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_FLUSH, "rz_flush_1");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_RECOV, "rz_recov_1");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, E_RECOV, "rz_recov_last_evt");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_FLUSH, "rz_flush_2");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_RECOV, "rz_recov_2a");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_RECOV, "rz_recov_2b");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IDLE,  "rz_normal");
        // reset mid-RECOVER; event while in reset is dropped
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, E_IDLE,  "mr_evt");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_FLUSH, "mr_flush");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_RECOV, "mr_recov");
        step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_RST_R, "mr_reset_in_recov");
        step(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, E_RST0,  "mr_reset_evt");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IDLE,  "mr_normal_1");
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IDLE,  "mr_normal_2");
        // 5 busy cycles from iq_full[1] plus two mispredicts
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, E_BUSY, "pf_iq1_busy");
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, E_IDLE,  "pf_evt");
            step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_FLUSH, "pf_flush");
            step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_RECOV, "pf_recov_1");
            step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_RECOV, "pf_recov_2");
        end
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, E_IDLE, "pf_normal");
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        for (int c = 0; c < 20 && sb_q.size() > 0; c++) @(negedge clock);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
        check("perf_stall_cycles", perf_stall_cycles, 32'd5);
        check("perf_flush_count", perf_flush_count, 32'd2);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
